// File: rtl/div_unit_if.sv
// Controller <-> divider handshake: start pulses, operands in, results and status out.
interface div_unit_if #(
   parameter int WIDTH = 32
);
   logic             div_start;
   logic             divu_start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             busy;
   logic             done;

   // Controller side: issues starts and operands, observes results.
   modport master (
      output div_start, divu_start, dividend, divisor,
      input  quotient, remainder, busy, done
   );

   // Divider side.
   modport slave (
      input  div_start, divu_start, dividend, divisor,
      output quotient, remainder, busy, done
   );
endinterface

// File: rtl/div_unit.sv
// Iterative signed/unsigned divider: radix-2 restoring division on operand
// magnitudes, one quotient bit per cycle, sign fix-up on the completing edge.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic      clk,
   input  logic      rst,
   div_unit_if.slave bus
);
   typedef enum logic {IDLE, RUN} state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic [5:0]         r_cnt;
   logic [WIDTH-1:0]   r_dividend;   // raw dividend, needed for the divide-by-zero result
   logic [WIDTH-1:0]   r_dvs_mag;    // divisor magnitude
   logic [WIDTH-1:0]   r_quo;        // dividend bits shift out, quotient bits shift in
   logic [WIDTH-1:0]   r_rem;        // partial remainder, always < divisor magnitude
   logic               r_neg_q;
   logic               r_neg_r;
   logic               r_dvz;
   logic [WIDTH-1:0]   r_quotient;
   logic [WIDTH-1:0]   r_remainder;
   logic               r_done;

   logic               w_accept;
   logic               w_last;
   logic               w_signed;
   logic [WIDTH-1:0]   w_dvd_mag;
   logic [WIDTH-1:0]   w_dvs_mag;
   logic [WIDTH:0]     w_shift;
   logic [WIDTH+1:0]   w_diff;
   logic               w_qbit;
   logic [WIDTH-1:0]   w_rem_step;
   logic [WIDTH-1:0]   w_quo_step;
   logic [WIDTH-1:0]   w_q_fin;
   logic [WIDTH-1:0]   w_r_fin;

   // Signed wins when both start pulses arrive together.
   assign w_accept = (r_state == IDLE) && (bus.div_start || bus.divu_start);
   assign w_last   = (r_state == RUN) && (r_cnt == 6'(WIDTH - 1));
   assign w_signed = bus.div_start;

   // Unsigned negation of 0x80000000 yields 2^31, which fits the unsigned magnitude.
   assign w_dvd_mag = (w_signed && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
   assign w_dvs_mag = (w_signed && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;

   // One restoring step: shift in the next dividend bit and trial-subtract.
   assign w_shift    = {r_rem, r_quo[WIDTH-1]};
   assign w_diff     = {1'b0, w_shift} - {2'b00, r_dvs_mag};
   assign w_qbit     = ~w_diff[WIDTH+1];
   assign w_rem_step = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
   assign w_quo_step = {r_quo[WIDTH-2:0], w_qbit};

   // Sign correction and the fixed divide-by-zero result.
   assign w_q_fin = r_dvz   ? '1 :
                    r_neg_q ? -w_quo_step : w_quo_step;
   assign w_r_fin = r_dvz   ? r_dividend :
                    r_neg_r ? -w_rem_step : w_rem_step;

   assign bus.quotient  = r_quotient;
   assign bus.remainder = r_remainder;
   assign bus.busy      = (r_state == RUN);
   assign bus.done      = r_done;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_state_next;
   end

   // Next-state: leave IDLE on an accepted start, return after the last iteration.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_next = RUN;
         RUN:     if (w_last)   w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Datapath: latch operands on accept, iterate while running, publish on completion.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt       <= '0;
         r_dividend  <= '0;
         r_dvs_mag   <= '0;
         r_quo       <= '0;
         r_rem       <= '0;
         r_neg_q     <= 1'b0;
         r_neg_r     <= 1'b0;
         r_dvz       <= 1'b0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_cnt      <= '0;
            r_dividend <= bus.dividend;
            r_dvs_mag  <= w_dvs_mag;
            r_quo      <= w_dvd_mag;
            r_rem      <= '0;
            r_neg_q    <= w_signed && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
            r_neg_r    <= w_signed && bus.dividend[WIDTH-1];
            r_dvz      <= (bus.divisor == '0);
         end else if (r_state == RUN) begin
            r_quo <= w_quo_step;
            r_rem <= w_rem_step;
            r_cnt <= r_cnt + 6'd1;
            if (w_last) begin
               r_cnt       <= '0;
               r_quotient  <= w_q_fin;
               r_remainder <= w_r_fin;
               r_done      <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: hand-computed quotient/remainder vectors,
// latency, start-ignore while busy, mid-operation reset, back-to-back starts.
module tb_div_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] prev_q = 32'd0;
   logic [31:0] prev_r = 32'd0;

   div_unit_if #(.WIDTH(32)) u_if();

   div_unit #(.WIDTH(32)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if)
   );

   always #5 clk = ~clk;

   // Single comparison point: counts and reports mismatches.
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   // mode: 0 = divu_start, 1 = div_start, 2 = both. inj > 0 pulses divu_start 9/3 at that cycle.
   task automatic run_op(input string tag, input int mode, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input int inj);
      int n;
      bit seen;
      seen = 1'b0;
      @(negedge clk);
      u_if.dividend   = a;
      u_if.divisor    = b;
      u_if.div_start  = (mode != 0);
      u_if.divu_start = (mode != 1);
      @(posedge clk); #1;
      chk({tag, " busy@start"}, 32'(u_if.busy), 32'd1);
      chk({tag, " done@start"}, 32'(u_if.done), 32'd0);
      n = 0;
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         u_if.div_start  = 1'b0;
         u_if.divu_start = (n == inj);
         u_if.dividend   = (n == inj) ? 32'd9 : ~a;
         u_if.divisor    = (n == inj) ? 32'd3 : (b ^ 32'h5A5A_5A5A);
         @(posedge clk); #1;
         if (n == 16) begin
            chk({tag, " q hold"}, u_if.quotient, prev_q);
            chk({tag, " r hold"}, u_if.remainder, prev_r);
         end
         if (u_if.done) seen = 1'b1;
      end
      u_if.divu_start = 1'b0;
      chk({tag, " latency"}, 32'(n), 32'd32);
      chk({tag, " busy@done"}, 32'(u_if.busy), 32'd0);
      chk({tag, " quotient"}, u_if.quotient, eq);
      chk({tag, " remainder"}, u_if.remainder, er);
      $display("op %-10s mode=%0d %h / %h -> q=%h r=%h (exp %h %h) cycles=%0d",
               tag, mode, a, b, u_if.quotient, u_if.remainder, eq, er, n);
      prev_q = eq;
      prev_r = er;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      bit seen_done;
      u_if.div_start  = 1'b0;
      u_if.divu_start = 1'b0;
      u_if.dividend   = 32'd0;
      u_if.divisor    = 32'd0;

      // Reset with a start held high throughout: must be ignored.
      #2 rst = 1'b0;
      u_if.div_start = 1'b1;
      u_if.dividend  = 32'd100;
      u_if.divisor   = 32'd7;
      repeat (3) @(posedge clk);
      #1;
      chk("rst busy", 32'(u_if.busy), 32'd0);
      chk("rst done", 32'(u_if.done), 32'd0);
      chk("rst q", u_if.quotient, 32'd0);
      chk("rst r", u_if.remainder, 32'd0);
      @(negedge clk);
      u_if.div_start = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("post-rst idle", 32'(u_if.busy), 32'd0);
      $display("reset: busy=%b done=%b q=%h r=%h", u_if.busy, u_if.done, u_if.quotient, u_if.remainder);

      run_op("u100/7", 0, 32'd100, 32'd7, 32'd14, 32'd2, 0);
      repeat (2) @(negedge clk);
      run_op("s-7/2", 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
      repeat (2) @(negedge clk);
      run_op("u-7/2", 0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 0);
      repeat (2) @(negedge clk);
      run_op("both-7/2", 2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
      repeat (2) @(negedge clk);
      run_op("s7/-2", 1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 0);
      repeat (2) @(negedge clk);
      run_op("s-100/-7", 1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 0);
      repeat (2) @(negedge clk);
      run_op("sMIN/-1", 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 0);
      repeat (2) @(negedge clk);
      run_op("u5/0", 0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 0);
      repeat (2) @(negedge clk);
      run_op("s-5/0", 1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 0);
      repeat (2) @(negedge clk);

      // A start pulsed while running must not disturb or queue behind the operation.
      run_op("inj100/7", 0, 32'd100, 32'd7, 32'd14, 32'd2, 10);
      repeat (3) @(posedge clk);
      #1;
      chk("inj no-restart", 32'(u_if.busy), 32'd0);
      $display("inject: busy after done=%b", u_if.busy);

      // Reset in the middle of an operation.
      @(negedge clk);
      u_if.dividend   = 32'd100;
      u_if.divisor    = 32'd7;
      u_if.divu_start = 1'b1;
      @(negedge clk);
      u_if.divu_start = 1'b0;
      repeat (15) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      chk("midrst busy", 32'(u_if.busy), 32'd0);
      chk("midrst done", 32'(u_if.done), 32'd0);
      chk("midrst q", u_if.quotient, 32'd0);
      chk("midrst r", u_if.remainder, 32'd0);
      seen_done = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         if (u_if.done) seen_done = 1'b1;
      end
      @(negedge clk);
      rst = 1'b1;
      repeat (20) begin
         @(posedge clk); #1;
         if (u_if.done) seen_done = 1'b1;
      end
      chk("midrst no-done", 32'(seen_done), 32'd0);
      $display("midreset: busy=%b q=%h r=%h done_seen=%b", u_if.busy, u_if.quotient, u_if.remainder, seen_done);
      prev_q = 32'd0;
      prev_r = 32'd0;
      run_op("u9/3", 0, 32'd9, 32'd3, 32'd3, 32'd0, 0);
      repeat (2) @(negedge clk);

      // Back-to-back: second start issued in the cycle where done is high.
      run_op("b2b100/7", 0, 32'd100, 32'd7, 32'd14, 32'd2, 0);
      run_op("b2b81/9", 0, 32'd81, 32'd9, 32'd9, 32'd0, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits; only 32 need be supported.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 div_start  input  1  start signed divide (DIV); one-cycle pulse from controller.
REQ-005 divu_start  input  1  start unsigned divide (DIVU); one-cycle pulse from controller.
REQ-006 dividend  input  32  Rs value; sampled only on an accepted start edge.
REQ-007 divisor  input  32  Rt value; sampled only on an accepted start edge.
REQ-008 quotient  output  32  result destined for LO.
REQ-009 remainder  output  32  result destined for HI.
REQ-010 busy  output  1  high while an operation is in progress; controller holds its final state while busy=1.
REQ-011 done  output  1  one-cycle pulse when results become valid.

Function
REQ-012 States SHALL be IDLE and RUN: IDLE->RUN on accepted start; RUN->IDLE after the 32nd iteration.
REQ-013 A start SHALL be accepted only in IDLE; while in RUN, starts SHALL be ignored and latched operands SHALL be unchanged.
REQ-014 If div_start and divu_start are both high, the operation SHALL be signed.
REQ-015 On the accepted start edge: operands and mode are latched, and busy=1 from that edge.
REQ-016 Algorithm SHALL be radix-2 restoring division on magnitudes, one quotient bit per cycle, with a 6-bit iteration counter counting 0..31.
REQ-017 Signed mode: magnitudes = two's-complement absolute values; quotient negated iff sign(dividend) XOR sign(divisor); remainder negated iff dividend negative.
REQ-018 Unsigned mode: operands SHALL be used as-is with no sign correction.
REQ-019 Latency: busy SHALL be high for exactly 32 cycles after the start edge; on the 32nd edge, quotient/remainder update, busy falls, and done=1 for that one cycle.
REQ-020 quotient/remainder SHALL change only on the completing edge and SHALL hold until the next completion.
REQ-021 Divisor = 0, both modes: quotient = 0xFFFFFFFF and remainder = dividend, with the full 32-cycle latency.
REQ-022 Signed 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000 and remainder = 0, with no error indication.
REQ-023 Magnitude of 0x80000000 SHALL be treated as 33-bit-safe, so |-2^31| = 2^31 unsigned.
REQ-024 A new start in the cycle where done=1 (state IDLE at that edge boundary) SHALL be accepted on the following edge.

Reset
REQ-025 rst=0 SHALL immediately (asynchronously) force: state IDLE, busy=0, done=0, quotient=0, remainder=0, counter=0, latched operands=0.
REQ-026 Reset asserted mid-operation SHALL abort the operation with no done pulse; after release, the block SHALL be idle and accept a start on the first edge.
REQ-027 Starts asserted while rst=0 SHALL be ignored.

Verification
REQ-028 divu_start, 100 / 7 -> busy for 32 cycles, done pulse, quotient = 14, remainder = 2.
REQ-029 div_start, -7 (0xFFFFFFF9) / 2 -> quotient = 0xFFFFFFFD (-3), remainder = 0xFFFFFFFF (-1); divu_start on the same operands -> quotient = 0x7FFFFFFC, remainder = 1.
REQ-030 div_start, 0x80000000 / 0xFFFFFFFF -> quotient = 0x80000000, remainder = 0; divu_start, 5 / 0 -> quotient = 0xFFFFFFFF, remainder = 5.
REQ-031 Start 100/7, pulse divu_start with 9/3 at cycle 10 of the operation -> results still 14 / 2 at done; no second operation begins.
REQ-032 Start 100/7, drive rst=0 at cycle 15 for 2 cycles -> busy, done, quotient and remainder all 0 immediately; no done pulse; a subsequent 9/3 yields quotient 3, remainder 0.
REQ-033 Back-to-back: start 100/7, then start 81/9 in the cycle after done -> second done at 32 cycles after its start edge, quotient = 9, remainder = 0.
